fetch_prefetch: RTL and testbench
=================================

// Module: fetch_prefetch
// PURPOSE
//  Parametrised successor of the single-entry IF stage: decouples PC generation from ID via an
//  in-order prefetch queue, with up to MAX_OUTSTANDING pipelined IMEM requests in flight.
//  Sits between the MMU/IMEM (request side) and ID (valid/ready side). Redirects from CSR/EXE
//  flush the queue and squash in-flight responses. Misaligned PCs raise an exception entry.
// PARAMETERS
//  XLEN            32            address/PC width
//  FIFO_DEPTH      4             prefetch queue entries (power of 2, >=2)
//  MAX_OUTSTANDING 2             IMEM requests in flight (1..FIFO_DEPTH)
//  PC_RESET        32'h8000_0000 PC after reset
// PORTS
//  clk             in   1        clock
//  rst_n           in   1        reset; one clock; asynchronous, active-low
//  mmu_vaddr_o     out  XLEN     virtual fetch address (= fetch_pc)
//  mmu_paddr_i     in   XLEN     translated address
//  mmu_hit_i       in   1        translation valid this cycle
//  imem_req_o      out  1        request issued (accepted same cycle)
//  imem_addr_o     out  XLEN     = mmu_paddr_i
//  imem_ack_i      in   1        response valid, in request order
//  imem_rdata_i    in   32       response instruction
//  csr_redirect_i  in   1        CSR/trap/WFI new-PC request (highest priority)
//  csr_pc_i        in   XLEN     CSR target
//  exe_redirect_i  in   1        branch/jump new-PC request
//  exe_pc_i        in   XLEN     EXE target
//  id_valid_o      out  1        queue head valid
//  id_ready_i      in   1        ID consumes head when valid&ready
//  id_instr_o      out  32       head instr (INSTR_NOP when exception entry)
//  id_pc_o         out  XLEN     head PC
//  id_exc_req_o    out  1        head carries exception
//  id_exc_code_o   out  type_exc_code_e  EXC_CODE_INSTR_MISALIGN or EXC_CODE_NO_EXCEPTION
//  if_stall_o      out  1        ~id_valid_o (queue empty) to forward/stall unit
// BEHAVIOUR
//  Reset: fetch_pc=PC_RESET; count, outstanding, drop_cnt, halt=0; id_valid_o=0, imem_req_o=0.
//  Issue: imem_req_o = mmu_hit_i & ~halt & ~redirect & ~misaligned & (outstanding<MAX_OUTSTANDING)
//   & (count+outstanding<FIFO_DEPTH). On issue: fetch_pc+=4, outstanding+=1, PC pushed to tag FIFO.
//  Response: imem_ack_i retires oldest outstanding; if drop_cnt>0, drop_cnt-=1 and data discarded,
//   else {rdata, tag PC, no exc} enqueued. No backpressure on ack; space is reserved at issue.
//  Misaligned (fetch_pc[1:0]!=0) and slot free: enqueue {NOP, fetch_pc, exc}, set halt; no IMEM req.
//   halt persists until next redirect.
//  Redirect (csr wins over exe, same cycle): fetch_pc<=target; count<=0; drop_cnt<=outstanding
//   minus ack this cycle; halt<=0; no issue that cycle; head dequeue that cycle ignored.
//  Dequeue: valid&ready pops head; simultaneous enqueue+dequeue keeps count; head latency from
//   ack to id_valid_o = 1 cycle (registered queue, no bypass).
//  Counters $clog2(FIFO_DEPTH+1) bits; read/write pointers wrap modulo FIFO_DEPTH.
//  Assertions: no enqueue when count==FIFO_DEPTH; ack never when outstanding==0.
// STRUCTURE
//  Package fetch_pkg: type_fetch_entry_s {instr, pc, exc_req, exc_code}, INSTR_NOP, PC_RESET default.
//  Exception codes reused from shared ISA package. Sub-module: fetch_queue (parametrised sync FIFO
//  of type_fetch_entry_s, push/pop/flush, count); instantiated for entries; tag FIFO for PCs.
// TESTING
//  1 Reset, ack 1 cycle after each req, id_ready=1 -> PCs 8000_0000,_0004,_0008 in order, 1/cycle.
//  2 id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 reqs issued, then imem_req_o=0 until pop.
//  3 Two reqs outstanding, exe_redirect to 8000_0100 -> both acks dropped, next head PC 8000_0100.
//  4 csr_redirect(8000_0200)+exe_redirect(8000_0300) same cycle -> head PC 8000_0200.
//  5 exe_redirect to 8000_0102 -> head exc_req=1, code INSTR_MISALIGN, instr NOP, no imem_req.
//  6 rst_n low mid-burst with acks pending -> outputs zero immediately, restart at PC_RESET.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
//   FETCH_XLEN       : address width the queue entry layout is built for
//   PC_RESET_DEFAULT : default fetch PC after reset
//   INSTR_NOP        : instruction placed in exception entries (addi x0,x0,0)
//   type_exc_code_e  : exception codes carried with a queue entry
//   type_fetch_entry_s : one prefetch queue entry {instr, pc, exc_req, exc_code}
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] PC_RESET_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [4:0] {
    EXC_CODE_INSTR_MISALIGN = 5'd0,
    EXC_CODE_NO_EXCEPTION   = 5'd31
  } type_exc_code_e;

  typedef struct packed {
    logic [31:0]           instr;
    logic [FETCH_XLEN-1:0] pc;
    logic                  exc_req;
    type_exc_code_e        exc_code;
  } type_fetch_entry_s;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of an arbitrary packed type with flush.
//   clk_i, rst_ni : clock, asynchronous active-low reset (control state only)
//   push_i/data_i : write one element (ignored while flush_i)
//   pop_i         : remove head element (ignored while flush_i or empty)
//   flush_i       : drop all contents
//   data_o        : head element (undefined when count_o == 0)
//   count_o       : number of stored elements
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter type T = logic [31:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output T                           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & (count_q != '0);

  // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH for free.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    do_push |-> (count_q != CW'(DEPTH)));

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage with an in-order prefetch queue.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   mmu_vaddr_o / mmu_paddr_i / mmu_hit_i : fetch address translation
//   imem_req_o / imem_addr_o   : IMEM request (accepted in the cycle it is raised)
//   imem_ack_i / imem_rdata_i  : in-order IMEM responses, no backpressure
//   csr_redirect_i/csr_pc_i    : highest-priority new PC
//   exe_redirect_i/exe_pc_i    : branch/jump new PC
//   id_valid_o/id_ready_i      : head handshake towards ID
//   id_instr_o/id_pc_o/id_exc_req_o/id_exc_code_o : head entry contents
//   if_stall_o                 : queue empty
// XLEN must equal fetch_pkg::FETCH_XLEN (the entry layout is fixed by the package).
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = FETCH_XLEN,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] PC_RESET        = PC_RESET_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] mmu_vaddr_o,
  input  logic [XLEN-1:0] mmu_paddr_i,
  input  logic            mmu_hit_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            csr_redirect_i,
  input  logic [XLEN-1:0] csr_pc_i,
  input  logic            exe_redirect_i,
  input  logic [XLEN-1:0] exe_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic            id_exc_req_o,
  output type_exc_code_e  id_exc_code_o,
  output logic            if_stall_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              halt_q, halt_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              active_q;

  logic [CW-1:0]     count, outstanding;
  logic [CW:0]       occupancy;
  logic              redirect, misaligned, slot_free, out_ok;
  logic              issue, drop, enq_resp, enq_exc, deq, q_empty;
  logic [XLEN-1:0]   redirect_pc, tag_pc;
  type_fetch_entry_s enq_entry, head_entry;

  assign redirect    = csr_redirect_i | exe_redirect_i;
  assign redirect_pc = csr_redirect_i ? csr_pc_i : exe_pc_i;
  assign misaligned  = fetch_pc_q[1:0] != 2'b00;

  // Queue space is reserved at issue time for every request in flight,
  // including ones that will be dropped, so an ack can always be enqueued.
  assign occupancy = {1'b0, count} + {1'b0, outstanding};
  assign slot_free = occupancy < (CW+1)'(FIFO_DEPTH);
  assign out_ok    = outstanding < CW'(MAX_OUTSTANDING);

  // active_q holds off requests for the first cycle after reset so no
  // output depends combinationally on the reset pin.
  assign issue = active_q & mmu_hit_i & ~halt_q & ~redirect & ~misaligned & out_ok & slot_free;

  assign drop     = drop_cnt_q != '0;
  assign enq_resp = imem_ack_i & ~drop & ~redirect;
  assign enq_exc  = active_q & misaligned & ~halt_q & ~redirect & slot_free & ~enq_resp;
  assign q_empty  = count == '0;
  assign deq      = ~q_empty & id_ready_i & ~redirect;

  always_comb begin
    enq_entry = '{instr: INSTR_NOP, pc: fetch_pc_q, exc_req: 1'b1,
                  exc_code: EXC_CODE_INSTR_MISALIGN};
    if (enq_resp) begin
      enq_entry = '{instr: imem_rdata_i, pc: tag_pc, exc_req: 1'b0,
                    exc_code: EXC_CODE_NO_EXCEPTION};
    end
  end

  // A redirect squashes everything still in flight: those responses are
  // counted off in drop_cnt as they return, including any ack this cycle.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halt_d     = halt_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      halt_d     = 1'b0;
      drop_cnt_d = outstanding - CW'(imem_ack_i);
    end else begin
      if (issue)              fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (enq_exc)            halt_d     = 1'b1;
      if (imem_ack_i && drop) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= PC_RESET;
      halt_q     <= 1'b0;
      drop_cnt_q <= '0;
      active_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halt_q     <= halt_d;
      drop_cnt_q <= drop_cnt_d;
      active_q   <= 1'b1;
    end
  end

  // Tag FIFO: PC of each request in flight; its fill level is the
  // outstanding count. Never flushed, since dropped acks still retire tags.
  fetch_queue #(.DEPTH(FIFO_DEPTH), .T(logic [XLEN-1:0])) u_tag_q (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (issue),
    .data_i  (fetch_pc_q),
    .pop_i   (imem_ack_i),
    .flush_i (1'b0),
    .data_o  (tag_pc),
    .count_o (outstanding)
  );

  fetch_queue #(.DEPTH(FIFO_DEPTH), .T(type_fetch_entry_s)) u_entry_q (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (enq_resp | enq_exc),
    .data_i  (enq_entry),
    .pop_i   (deq),
    .flush_i (redirect),
    .data_o  (head_entry),
    .count_o (count)
  );

  assign mmu_vaddr_o   = fetch_pc_q;
  assign imem_req_o    = issue;
  assign imem_addr_o   = mmu_paddr_i;
  assign id_valid_o    = ~q_empty;
  assign id_instr_o    = head_entry.instr;
  assign id_pc_o       = head_entry.pc;
  assign id_exc_req_o  = head_entry.exc_req;
  assign id_exc_code_o = head_entry.exc_code;
  assign if_stall_o    = q_empty;

  a_ack_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_ack_i |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mmu_vaddr, mmu_paddr, imem_addr, imem_rdata, csr_pc, exe_pc;
  logic [31:0] id_instr, id_pc;
  logic        mmu_hit, imem_req, imem_ack, csr_redirect, exe_redirect;
  logic        id_valid, id_ready, id_exc_req, if_stall;
  type_exc_code_e id_exc_code;

  always #5 clk = ~clk;

  assign mmu_paddr = mmu_vaddr;

  fetch_prefetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mmu_vaddr_o    (mmu_vaddr),
    .mmu_paddr_i    (mmu_paddr),
    .mmu_hit_i      (mmu_hit),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ack_i     (imem_ack),
    .imem_rdata_i   (imem_rdata),
    .csr_redirect_i (csr_redirect),
    .csr_pc_i       (csr_pc),
    .exe_redirect_i (exe_redirect),
    .exe_pc_i       (exe_pc),
    .id_valid_o     (id_valid),
    .id_ready_i     (id_ready),
    .id_instr_o     (id_instr),
    .id_pc_o        (id_pc),
    .id_exc_req_o   (id_exc_req),
    .id_exc_code_o  (id_exc_code),
    .if_stall_o     (if_stall)
  );

  typedef struct {
    logic [31:0]    instr;
    logic [31:0]    pc;
    logic           exc;
    type_exc_code_e code;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];
  int    pop_cyc_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc = 0;
  int    req_count = 0;
  int    ack_lat = 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic exc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.exc   = exc;
    e.code  = exc ? EXC_CODE_INSTR_MISALIGN : EXC_CODE_NO_EXCEPTION;
    exp_q.push_back(e);
  endtask

  // Hold mmu_hit until exactly n requests have been issued.
  task automatic fetch_n(input int n, input string name);
    int start;
    int k;
    start   = req_count;
    k       = 0;
    mmu_hit = 1'b1;
    while ((req_count - start) < n && k < 40) begin
      cycle();
      k++;
    end
    mmu_hit = 1'b0;
    chk(name, 128'(req_count - start), 128'(n));
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      cycle();
      k++;
    end
    chk(name, 128'(exp_q.size()), 128'(0));
    repeat (4) cycle();
  endtask

  task automatic redirect(input logic c, input logic [31:0] cpc,
                          input logic e, input logic [31:0] epc);
    csr_redirect = c;
    csr_pc       = cpc;
    exe_redirect = e;
    exe_pc       = epc;
    cycle();
    csr_redirect = 1'b0;
    exe_redirect = 1'b0;
  endtask

  // IMEM model: records each request at the falling edge and acks it
  // ack_lat cycles later, in order, with instr = {addr[15:0], 16'h0013}.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        imem_ack   = 1'b1;
        imem_rdata = {pend_q[0].addr[15:0], 16'h0013};
        void'(pend_q.pop_front());
      end else begin
        imem_ack = 1'b0;
      end
      @(negedge clk);
      if (!rst_n) begin
        pend_q.delete();
      end else if (imem_req) begin
        pend_q.push_back('{addr: imem_addr, due: cyc + ack_lat});
        req_count++;
      end
    end
  end

  // Monitor: every head consumed by ID is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && id_valid && id_ready) begin
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_head: got pc %0h instr %0h, required no entry", id_pc, id_instr);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("head_%0h", e.pc),
              128'({id_instr, id_pc, id_exc_req, id_exc_code}),
              128'({e.instr, e.pc, e.exc, e.code}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n        = 1'b0;
    mmu_hit      = 1'b1;
    id_ready     = 1'b1;
    csr_redirect = 1'b0;
    exe_redirect = 1'b0;
    csr_pc       = '0;
    exe_pc       = '0;
    cycle();
    cycle();
    @(negedge clk);
    chk("rst_id_valid", 128'(id_valid), 128'(0));
    chk("rst_imem_req", 128'(imem_req), 128'(0));
    chk("rst_vaddr", 128'(mmu_vaddr), 128'(32'h8000_0000));
    chk("rst_if_stall", 128'(if_stall), 128'(1));
    cycle();
    rst_n   = 1'b1;
    mmu_hit = 1'b0;

    // 1: three sequential fetches, one head per cycle
    push_exp(32'h8000_0000, 32'h0000_0013, 1'b0);
    push_exp(32'h8000_0004, 32'h0004_0013, 1'b0);
    push_exp(32'h8000_0008, 32'h0008_0013, 1'b0);
    fetch_n(3, "t1_reqs");
    drain("t1_drain");
    chk("t1_back_to_back", 128'(pop_cyc_q[pop_cyc_q.size()-1] - pop_cyc_q[pop_cyc_q.size()-3]), 128'(2));

    // 2: ID stalled, queue depth limits requests to 4
    id_ready = 1'b0;
    mmu_hit  = 1'b1;
    n0       = req_count;
    repeat (10) cycle();
    @(negedge clk);
    chk("t2_req_count", 128'(req_count - n0), 128'(4));
    chk("t2_req_blocked", 128'(imem_req), 128'(0));
    chk("t2_id_valid", 128'(id_valid), 128'(1));
    push_exp(32'h8000_000C, 32'h000C_0013, 1'b0);
    push_exp(32'h8000_0010, 32'h0010_0013, 1'b0);
    push_exp(32'h8000_0014, 32'h0014_0013, 1'b0);
    push_exp(32'h8000_0018, 32'h0018_0013, 1'b0);
    cycle();
    mmu_hit  = 1'b0;
    id_ready = 1'b1;
    drain("t2_drain");

    // 3: redirect with two requests in flight drops both responses
    ack_lat = 3;
    fetch_n(2, "t3_reqs");
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0100);
    ack_lat = 1;
    push_exp(32'h8000_0100, 32'h0100_0013, 1'b0);
    fetch_n(1, "t3_req_after");
    drain("t3_drain");

    // 4: CSR wins over EXE in the same cycle
    redirect(1'b1, 32'h8000_0200, 1'b1, 32'h8000_0300);
    @(negedge clk);
    chk("t4_vaddr", 128'(mmu_vaddr), 128'(32'h8000_0200));
    push_exp(32'h8000_0200, 32'h0200_0013, 1'b0);
    cycle();
    fetch_n(1, "t4_reqs");
    drain("t4_drain");

    // 5: misaligned target produces an exception entry and halts fetch
    push_exp(32'h8000_0102, 32'h0000_0013, 1'b1);
    mmu_hit = 1'b1;
    n0      = req_count;
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0102);
    drain("t5_drain");
    @(negedge clk);
    chk("t5_no_req", 128'(req_count - n0), 128'(0));
    chk("t5_halted", 128'(imem_req), 128'(0));
    cycle();
    mmu_hit = 1'b0;
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0400);

    // 6: reset in the middle of a burst with responses pending
    ack_lat  = 2;
    id_ready = 1'b0;
    mmu_hit  = 1'b1;
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    chk("t6_id_valid", 128'(id_valid), 128'(0));
    chk("t6_imem_req", 128'(imem_req), 128'(0));
    chk("t6_vaddr", 128'(mmu_vaddr), 128'(32'h8000_0000));
    chk("t6_if_stall", 128'(if_stall), 128'(1));
    cycle();
    cycle();
    mmu_hit  = 1'b0;
    ack_lat  = 1;
    id_ready = 1'b1;
    rst_n    = 1'b1;
    push_exp(32'h8000_0000, 32'h0000_0013, 1'b0);
    fetch_n(1, "t6_reqs");
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
